// File: rtl/int_responder.sv
// int_responder: external interrupt source. Raises requests on a cycle schedule
// and treats a store to the acknowledge address as the acknowledge that clears each one.
module int_responder #(
  parameter logic [31:0] INT_ADDR    = 32'h0000_7F20,
  parameter logic [31:0] FIRST_DELAY = 32'd8,
  parameter logic [31:0] PERIOD      = 32'd16,
  parameter logic [7:0]  MAX_INT     = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] int_addr,
  input  logic [3:0]  int_byteen,
  output logic        interrupt,
  output logic [7:0]  int_cnt,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for en to start the schedule
  // WAIT  | counting down to the next request (frozen while en=0)
  // REQ   | request raised, waiting for an acknowledge store
  // DONE  | MAX_INT requests acknowledged, terminal until reset
  typedef enum logic [1:0] {IDLE, WAIT, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        interrupt_q, interrupt_d;
  logic [7:0]  int_cnt_q, int_cnt_d;
  logic        done_q, done_d;

  logic ack;
  logic last_ack;
  logic unused_addr_bits;

  assign ack      = (int_addr[31:2] == INT_ADDR[31:2]) && (|int_byteen);
  assign last_ack = (MAX_INT != 8'd0) && (({1'b0, int_cnt_q} + 9'd1) == {1'b0, MAX_INT});
  assign unused_addr_bits = ^int_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    interrupt_d = interrupt_q;
    int_cnt_d   = int_cnt_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (FIRST_DELAY == 32'd0) begin
            state_d     = REQ;
            interrupt_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = FIRST_DELAY - 32'd1;
          end
        end
      end
      WAIT: begin
        if (en) begin
          if (cnt_q == 32'd0) begin
            state_d     = REQ;
            interrupt_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
      end
      REQ: begin
        // With PERIOD=0 we stay here and the request re-raises on the following edge.
        interrupt_d = 1'b1;
        if (ack) begin
          interrupt_d = 1'b0;
          int_cnt_d   = (int_cnt_q == 8'hFF) ? 8'hFF : int_cnt_q + 8'd1;
          if (last_ack) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (PERIOD != 32'd0) begin
            state_d = WAIT;
            cnt_d   = PERIOD - 32'd1;
          end
        end
      end
      DONE: begin
        interrupt_d = 1'b0;
        done_d      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 32'd0;
      interrupt_q <= 1'b0;
      int_cnt_q   <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      interrupt_q <= interrupt_d;
      int_cnt_q   <= int_cnt_d;
      done_q      <= done_d;
    end
  end

  assign interrupt = interrupt_q;
  assign int_cnt   = int_cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_int_responder.sv
// Bench for int_responder: directed schedule checks with literal expectations,
// then randomized en/ack/reset traffic compared every cycle against a behavioural model.
module tb_int_responder;

  localparam int FIRST_DELAY = 8;
  localparam int PERIOD      = 16;
  localparam int MAX_INT     = 4;
  localparam int ACK_WORD    = 32'h7F20 >> 2;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_REQ  = 2;
  localparam int PH_FIN  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] int_addr = 32'd0;
  logic [3:0]  int_byteen = 4'd0;
  logic        interrupt;
  logic [7:0]  int_cnt;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: edges-remaining-until-request plus a count of acknowledges.
  int m_phase = PH_IDLE;
  int m_left  = 0;
  int m_irq   = 0;
  int m_acks  = 0;
  int m_done  = 0;

  int_responder dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .int_addr   (int_addr),
    .int_byteen (int_byteen),
    .interrupt  (interrupt),
    .int_cnt    (int_cnt),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = PH_IDLE;
      m_left  = 0;
      m_irq   = 0;
      m_acks  = 0;
      m_done  = 0;
    end else begin
      bit is_ack;
      is_ack = ((int_addr >> 2) == ACK_WORD) && (int_byteen != 4'd0);
      case (m_phase)
        PH_IDLE: if (en) begin
          if (FIRST_DELAY == 0) begin m_phase = PH_REQ; m_irq = 1; end
          else begin m_phase = PH_WAIT; m_left = FIRST_DELAY; end
        end
        PH_WAIT: if (en) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = PH_REQ; m_irq = 1; end
        end
        PH_REQ: begin
          if (is_ack) begin
            m_irq  = 0;
            m_acks = (m_acks >= 255) ? 255 : m_acks + 1;
            if (MAX_INT != 0 && m_acks == MAX_INT) begin m_phase = PH_FIN; m_done = 1; end
            else if (PERIOD != 0) begin m_phase = PH_WAIT; m_left = PERIOD; end
          end else begin
            m_irq = 1;
          end
        end
        default: begin m_irq = 0; m_done = 1; end
      endcase
    end
  end

  always @(negedge clk) begin
    check("interrupt", int'(interrupt), m_irq);
    check("int_cnt", int'(int_cnt), m_acks);
    check("done", int'(done), m_done);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (interrupt) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic ack_pulse(input logic [31:0] a, input logic [3:0] be);
    int_addr   = a;
    int_byteen = be;
    step();
    int_addr   = 32'd0;
    int_byteen = 4'd0;
  endtask

  initial begin
    int r;
    int total;
    #1 reset = 1'b0;
    repeat (3) step();
    check("reset_interrupt", int'(interrupt), 0);
    check("reset_int_cnt", int'(int_cnt), 0);
    check("reset_done", int'(done), 0);

    reset = 1'b1;
    step();
    en = 1'b1;
    step();
    wait_rise(40, r);
    check("first_latency", r, 8);
    check("first_int_cnt", int'(int_cnt), 0);

    repeat (50) step();
    check("held_no_ack_irq", int'(interrupt), 1);
    check("held_no_ack_cnt", int'(int_cnt), 0);

    ack_pulse(32'h7F20, 4'b0001);
    check("ack1_irq", int'(interrupt), 0);
    check("ack1_cnt", int'(int_cnt), 1);
    wait_rise(40, r);
    check("period_latency", r, 16);

    ack_pulse(32'h7F24, 4'b1111);
    check("wrong_addr_ignored", int'(interrupt), 1);
    ack_pulse(32'h7F20, 4'b0000);
    check("no_byteen_ignored", int'(interrupt), 1);
    ack_pulse(32'h7F23, 4'b1000);
    check("low_bits_ack_irq", int'(interrupt), 0);
    check("low_bits_ack_cnt", int'(int_cnt), 2);
    wait_rise(40, r);
    check("period_latency2", r, 16);

    ack_pulse(32'h7F20, 4'b0010);
    check("ack3_cnt", int'(int_cnt), 3);
    repeat (4) step();
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    wait_rise(40, r);
    total = (r < 0) ? -1 : 9 + r;
    check("en_pause_latency", total, 21);

    ack_pulse(32'h7F20, 4'b1111);
    check("ack4_done", int'(done), 1);
    check("ack4_irq", int'(interrupt), 0);
    check("ack4_cnt", int'(int_cnt), 4);
    int_addr   = 32'h7F20;
    int_byteen = 4'b0001;
    repeat (20) step();
    int_addr   = 32'd0;
    int_byteen = 4'd0;
    check("done_ack_cnt", int'(int_cnt), 4);
    check("done_irq", int'(interrupt), 0);
    check("done_sticky", int'(done), 1);

    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    wait_rise(40, r);
    check("restart_latency", r, 8);
    repeat (3) step();
    #2 reset = 1'b0;
    #1 check("async_reset_irq", int'(interrupt), 0);
    check("async_reset_cnt", int'(int_cnt), 0);
    step();
    en = 1'b0;
    reset = 1'b1;
    repeat (20) step();
    check("idle_after_reset", int'(interrupt), 0);
    en = 1'b1;
    step();
    wait_rise(40, r);
    check("idle_restart_latency", r, 8);

    for (int c = 0; c < 4000; c++) begin
      step();
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: int_addr = 32'h7F20 + $urandom_range(0, 3);
          1: int_addr = 32'h7F24;
          2: int_addr = 32'h7F1C;
          default: int_addr = $urandom;
        endcase
        int_byteen = 4'($urandom_range(0, 15));
      end else begin
        int_addr   = 32'd0;
        int_byteen = 4'd0;
      end
      reset = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
